// File: rtl/sys1_video_timing_if.sv
// Raster timing bus between the System 1/2 timing generator and its consumers
// (system top, video block, VGA encoder side).
interface sys1_video_timing_if;
  // No handshake: the master drives a free-running raster; every output is a
  // registered level, PCE/VBIRQ are single-cycle strobes. HOFS is sampled only at frame start.
  logic [3:0] HOFS;
  logic       PCE;
  logic       PCLK;
  logic [8:0] PH;
  logic [8:0] PV;
  logic       HBLK;
  logic       VBLK;
  logic       HSYNC;
  logic       VSYNC;
  logic       VBIRQ;
  logic [7:0] FRAME;

  modport master (
    input  HOFS,
    output PCE, PCLK, PH, PV, HBLK, VBLK, HSYNC, VSYNC, VBIRQ, FRAME
  );

  modport slave (
    output HOFS,
    input  PCE, PCLK, PH, PV, HBLK, VBLK, HSYNC, VSYNC, VBIRQ, FRAME
  );
endinterface

// File: rtl/sys1_video_timing.sv
// Raster timing for the SEGA System 1/2 video pipeline: pixel clock enable,
// PH/PV counters, blanking, sync, vblank interrupt and frame counter on clk48M.
module sys1_video_timing #(
  parameter int CE_DIV   = 8,
  parameter int H_TOTAL  = 384,
  parameter int H_ACTIVE = 256,
  parameter int HS_START = 304,
  parameter int HS_WIDTH = 32,
  parameter int V_TOTAL  = 262,
  parameter int V_ACTIVE = 224,
  parameter int VS_START = 240,
  parameter int VS_WIDTH = 3
) (
  input  logic                  clk48M,
  input  logic                  reset_n,
  sys1_video_timing_if.master   vt
);
  localparam int DW = $clog2(CE_DIV);

  logic [DW-1:0] div;
  logic [3:0]    hofs_l;
  logic          tick;
  logic          line_end;
  logic          frame_end;
  logic [8:0]    ph_n;
  logic [8:0]    pv_n;
  logic [3:0]    hofs_n;
  logic [9:0]    hss;
  logic [10:0]   hse;
  logic          hs_on;
  logic          vs_on;

  // Everything is computed on the next PH/PV so decodes never lag the counters.
  always_comb begin
    tick      = (div == DW'(CE_DIV - 1));
    line_end  = (vt.PH == 9'(H_TOTAL - 1));
    frame_end = line_end && (vt.PV == 9'(V_TOTAL - 1));
    ph_n      = line_end ? 9'd0 : vt.PH + 9'd1;
    pv_n      = vt.PV;
    if (line_end) pv_n = frame_end ? 9'd0 : vt.PV + 9'd1;
    hofs_n    = (ph_n == 9'd0 && pv_n == 9'd0) ? vt.HOFS : hofs_l;
    hss       = 10'(HS_START) + {{6{hofs_n[3]}}, hofs_n};
    hse       = {1'b0, hss} + 11'(HS_WIDTH);
    hs_on     = ({1'b0, ph_n} >= hss) && ({2'b00, ph_n} < hse);
    vs_on     = (pv_n >= 9'(VS_START)) && (pv_n < 9'(VS_START + VS_WIDTH));
  end

  always_ff @(posedge clk48M) begin
    if (!reset_n) begin
      div      <= '0;
      hofs_l   <= 4'd0;
      vt.PCE   <= 1'b0;
      vt.PCLK  <= 1'b0;
      vt.PH    <= 9'd0;
      vt.PV    <= 9'd0;
      vt.HBLK  <= 1'b0;
      vt.VBLK  <= 1'b0;
      vt.HSYNC <= 1'b1;
      vt.VSYNC <= 1'b1;
      vt.VBIRQ <= 1'b0;
      vt.FRAME <= 8'd0;
    end else begin
      div      <= tick ? '0 : div + DW'(1);
      vt.PCE   <= tick;
      vt.PCLK  <= (div >= DW'(CE_DIV / 2));
      vt.VBIRQ <= 1'b0;
      if (tick) begin
        vt.PH    <= ph_n;
        vt.PV    <= pv_n;
        hofs_l   <= hofs_n;
        vt.HBLK  <= (ph_n >= 9'(H_ACTIVE));
        vt.VBLK  <= (pv_n >= 9'(V_ACTIVE));
        vt.HSYNC <= !hs_on;
        vt.VSYNC <= !vs_on;
        vt.VBIRQ <= (ph_n == 9'd0) && (pv_n == 9'(V_ACTIVE));
        if (frame_end) vt.FRAME <= vt.FRAME + 8'd1;
      end
    end
  end
endmodule
